// File: rtl/vpi_word_to_byte_stream_pkg.sv
// Shared constants for the VPI word-to-byte serialiser: byte width, FSM encoding
// and a constant-evaluable ceil(log2) used to size the byte-count port.
package vpi_word_to_byte_stream_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Smallest n with 2**n >= value; usable in parameter/port declarations.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vpi_word_to_byte_stream.sv
// Serialises multi-byte words (with valid-byte count and end-of-file flag) into
// a byte-wide valid/ready stream, marking the final byte of the file with tlast.
module vpi_word_to_byte_stream
    import vpi_word_to_byte_stream_pkg::*;
#(
    parameter int BUS_WIDTH = 5,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BUS_WIDTH*BYTE_W-1:0]       s_tdata,
    input  logic [clog2(BUS_WIDTH+1)-1:0]     s_tcount,
    input  logic                              s_tlast,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    output logic [BYTE_W-1:0]                 m_tdata,
    output logic                              m_tlast,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [31:0]                       byte_count
);

    localparam int WORD_W = BUS_WIDTH * BYTE_W;
    localparam int CNT_W  = clog2(BUS_WIDTH + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BUS_WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t             state_reg;
    logic [WORD_W-1:0]  data_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic               last_reg;
    logic [31:0]        byte_count_reg;

    logic [WORD_W-1:0]  shifted_next;
    logic [CNT_W-1:0]   eff_count;
    logic               accept;
    logic               handoff;
    logic               on_final_byte;

    // Word register moved one byte toward the emit side, zero-filling behind.
    genvar gi;
    generate
        for (gi = 0; gi < BUS_WIDTH; gi++) begin : g_shift
            if (LSB_FIRST) begin : g_lsb
                if (gi == BUS_WIDTH - 1) begin : g_fill
                    assign shifted_next[gi*BYTE_W +: BYTE_W] = '0;
                end else begin : g_move
                    assign shifted_next[gi*BYTE_W +: BYTE_W] = data_reg[(gi+1)*BYTE_W +: BYTE_W];
                end
            end else begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted_next[gi*BYTE_W +: BYTE_W] = '0;
                end else begin : g_move
                    assign shifted_next[gi*BYTE_W +: BYTE_W] = data_reg[(gi-1)*BYTE_W +: BYTE_W];
                end
            end
        end

        if (LSB_FIRST) begin : g_emit_lsb
            assign m_tdata = data_reg[BYTE_W-1:0];
        end else begin : g_emit_msb
            assign m_tdata = data_reg[WORD_W-1 -: BYTE_W];
        end
    endgenerate

    assign eff_count     = (s_tcount > MAX_CNT) ? MAX_CNT : s_tcount;
    assign on_final_byte = (remaining_reg == ONE_CNT);

    assign m_tvalid   = (state_reg == ST_SHIFT);
    assign m_tlast    = last_reg & on_final_byte;
    assign byte_count = byte_count_reg;

    // A new word may load in the same cycle the last byte of the current one leaves.
    assign s_tready = ~rst & ((state_reg == ST_IDLE) | (on_final_byte & m_tready));
    assign accept   = s_tvalid & s_tready;
    assign handoff  = m_tvalid & m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            data_reg       <= '0;
            remaining_reg  <= '0;
            last_reg       <= 1'b0;
            byte_count_reg <= '0;
        end else begin
            if (handoff) begin
                byte_count_reg <= byte_count_reg + 32'd1;
            end

            if (accept) begin
                data_reg      <= s_tdata;
                remaining_reg <= eff_count;
                last_reg      <= s_tlast;
                state_reg     <= (eff_count != '0) ? ST_SHIFT : ST_IDLE;
            end else if (handoff) begin
                data_reg      <= shifted_next;
                remaining_reg <= remaining_reg - ONE_CNT;
                if (on_final_byte) begin
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: doc/vpi_word_to_byte_stream.md
Name: vpi_word_to_byte_stream

Overview:
- Downstream stage of the VPI binary file reader. Accepts multi-byte words, each with a valid-byte count and an end-of-file flag, as returned by a `$read_binary_file` call.
- Serialises each word into a byte-wide valid/ready stream with tlast on the final byte of the file.
- The byte stream feeds the `$write_binary_file` writer or a byte-oriented DUT.
- Synthesisable; used both in benches and as a reusable adapter.

Parameters:
- BUS_WIDTH, 5, input word width in bytes (5 = 40-bit vector).
- LSB_FIRST, 1, 1: byte 0 = s_tdata[7:0] is emitted first; 0: the most significant byte is emitted first.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  BUS_WIDTH*8  input word.
- s_tcount  in  $clog2(BUS_WIDTH+1)  number of valid bytes in s_tdata (the read count).
- s_tlast  in  1  word is the last of the file (the read returned < 0).
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input word accepted when s_tvalid & s_tready.
- m_tdata  out  8  output byte.
- m_tlast  out  1  marks the final byte of the file.
- m_tvalid  out  1  output byte valid.
- m_tready  in  1  downstream ready.
- byte_count  out  32  running count of bytes handed off (m_tvalid & m_tready); wraps at 2^32.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: m_tdata=0, m_tlast=0, m_tvalid=0, byte_count=0, state=IDLE, remaining=0. s_tready is 0 while rst is high.
- State machine, two states:
  - IDLE: s_tready=1, m_tvalid=0.
  - SHIFT: m_tvalid=1.
- Word acceptance:
  - Valid bytes are the low s_tcount bytes when LSB_FIRST=1, or the high s_tcount bytes when LSB_FIRST=0.
  - s_tcount > BUS_WIDTH saturates to BUS_WIDTH.
  - On accept, the word is registered, remaining = effective count, last_q = s_tlast. The state moves to SHIFT if count > 0.
- Latency: the first byte appears on m_tdata with m_tvalid=1 on the cycle after acceptance.
- Throughput: one byte per cycle while m_tready=1.
- Byte handoff (m_tvalid & m_tready): shift the register by 8 toward the emit side, decrement remaining, increment byte_count.
- m_tlast = last_q & (remaining==1). m_tdata, m_tlast and m_tvalid are held stable while m_tready=0 (AXI-stream rule).
- Back-to-back words: in SHIFT, s_tready = (remaining==1) & m_tready. A word accepted in that cycle loads directly, with no bubble. Otherwise the state returns to IDLE after the last byte.
- Zero-count word:
  - Accepted and dropped, no output; the state stays IDLE, or goes to IDLE if loaded during back-to-back.
  - If it carries s_tlast, no byte gets tlast. Writers use s_tlast only as advisory, so this is acceptable and documented.
- rst mid-word: remaining bytes are discarded, all outputs return to reset values next cycle, and byte_count clears.
- m_tready held low: no state change; s_tready stays 0 in SHIFT.

Decomposition:
- Shared package: byte width constant (8), state encoding constants (IDLE=0, SHIFT=1), count width function clog2.
- No sub-module. The shift register, counter and FSM live in one module of roughly 150-200 lines.

Test Plan:
- Single 5-byte word 0x0403020100, count=5, last=1, m_tready=1 → bytes 00,01,02,03,04 on 5 consecutive cycles starting 1 cycle after accept; tlast only on 04; byte_count=5.
- Partial word 0xFFFFFF0B0A, count=2, last=1, LSB_FIRST=1 → bytes 0A,0B only; tlast on 0B; byte_count=2.
- Two back-to-back words (0x0403020100 and 0x0908070605), count=5 each, last on the second, s_tvalid held high → 10 bytes 00..09 with no bubble cycle; s_tready pulses exactly on the cycles emitting 04 and 09; tlast only on 09.
- Backpressure: m_tready toggles 1,0,0,1,... during a word → m_tdata is held unchanged while low; byte order and total of 5 bytes are preserved; s_tready stays 0 until the last byte.
- Reset mid-word after 2 of 5 bytes → the next cycle has m_tvalid=0, byte_count=0, s_tready=1; a new word 0x1111111111 then emits five 11 bytes.
- Zero-count word, then count=6 on BUS_WIDTH=5 → the first is dropped with no m_tvalid; the second saturates and emits 5 bytes.
